axis_frame_capture: RTL
=======================

# axis_frame_capture

AXI4-Stream slave that terminates a radar sample stream, such as the ROM-fed test source, and captures one frame of beats into an internal dual-port buffer. The block checks frame length against `FRAME_LEN` and the byte strobes, then holds the captured frame for random-access readback. It is the sink-side counterpart used in the ROM/IP bring-up designs, instantiated inside the block design alongside the stream source.

## Interface
- `S_AXIS_TDATA_WIDTH`, 32: stream data width, multiple of 8.
- `ADDRW`, 14: buffer address width; depth is 2^ADDRW words.
- `FRAME_LEN`, 16384: expected beats per frame, 1 ≤ FRAME_LEN ≤ 2^ADDRW.
- `s_axis_aclk`  in  1: sole clock; all logic is rising-edge.
- `s_axis_aresetn`  in  1: synchronous, active-low reset.
- `S_AXIS_tdata`  in  S_AXIS_TDATA_WIDTH: stream data.
- `S_AXIS_tstrb`  in  S_AXIS_TDATA_WIDTH/8: byte strobes; all-ones is required.
- `S_AXIS_tlast`  in  1: last beat of frame.
- `S_AXIS_tvalid`  in  1: source has a beat.
- `S_AXIS_tready`  out  1: sink accepts a beat; registered.
- `arm`  in  1: single-cycle pulse that starts a capture.
- `busy`  out  1: high in CAPTURE.
- `done`  out  1: high in DONE.
- `beat_count`  out  ADDRW+1: beats accepted in the current or last frame.
- `err_len`  out  1: sticky; frame length mismatch.
- `err_strb`  out  1: sticky; a beat had a non-all-ones strobe.
- `rd_addr`  in  ADDRW: readback address.
- `rd_data`  out  S_AXIS_TDATA_WIDTH: `mem[rd_addr]`, one-cycle latency.

## Operation
- States: IDLE, CAPTURE, DONE.
- Beat accepted means `S_AXIS_tvalid && S_AXIS_tready` at a clock edge.
- IDLE: `tready`=0. `arm`=1 moves to CAPTURE and clears `wr_addr`, `beat_count`, `err_len` and `err_strb`.
- CAPTURE: `tready`=1. Each accepted beat:
  - writes `tdata` to `mem[wr_addr]`;
  - increments `wr_addr` and `beat_count`;
  - sets `err_strb` if `tstrb` is not all ones. The data is still written.
- Frame end in CAPTURE, where n = `beat_count`+1 on the accepted beat:
  - `tlast`=1 and n==FRAME_LEN: go to DONE, no error.
  - `tlast`=1 and n<FRAME_LEN: early end. Set `err_len`, go to DONE.
  - `tlast`=0 and n==FRAME_LEN: missing tlast. Set `err_len`, go to DONE. Later beats from the source stay stalled.
- DONE: `tready`=0 and `done`=1. `arm` restarts in CAPTURE exactly as from IDLE. Buffer contents and `beat_count` hold until re-armed.
- `arm` is ignored while in CAPTURE.
- `wr_addr` never wraps, because FRAME_LEN ≤ 2^ADDRW.
- The read port is independent of state. Reading the address being written in the same cycle returns the old data (read-first).
- `tdata`, `tstrb` and `tlast` are ignored whenever `tready`=0.

## Timing
- Reset values: `tready`=0, `busy`=0, `done`=0, `beat_count`=0, `err_len`=0, `err_strb`=0, state IDLE. `rd_data` is undefined until the first read. Memory is not cleared.
- `tready` is registered from the next state:
  - It rises on the edge that samples `arm`, so the first beat can be accepted one cycle after the `arm` cycle.
  - It falls on the same edge that accepts the final beat, so no extra beat is ever accepted.
- At full throughput (`tvalid` held high), the block accepts one beat per cycle. FRAME_LEN beats take FRAME_LEN cycles.
- `done`, `busy`, `beat_count` and the error flags update on the edge that accepts the beat causing them.
- `rd_data` is valid on the edge following the `rd_addr` edge.
- Reset mid-frame:
  - The next edge returns to IDLE with all outputs at reset values.
  - The partially written buffer is retained.
  - The source sees `tready`=0 and must restart its frame.
- Source stalls (`tvalid`=0) in CAPTURE: state, count and address hold.

## Test plan
Bench parameters: ADDRW=4, FRAME_LEN=16.

1. Nominal frame. Stimulus: reset, pulse `arm`, then 16 beats back-to-back with data 0x1000+i, tstrb=0xF, and tlast on beat 15. Required: `done`=1, `beat_count`=16, no errors, `tready`=0 after beat 15. Reading addr 0..15 returns 0x1000..0x100F with one-cycle latency.
2. Early tlast. Stimulus: tlast on beat 9. Required: `err_len`=1, `beat_count`=10, DONE.
3. Missing tlast. Stimulus: the source drives 20 beats with no tlast. Required: exactly 16 accepted, `err_len`=1, `tready` stays 0, and beat 17 is never written.
4. Backpressure and stalls. Stimulus: `tvalid` toggles 1/0 every cycle. Required: 16 beats captured in order; the count holds during stalls.
5. Bad strobe. Stimulus: tstrb=0x7 on beat 3. Required: `err_strb`=1 sticky, the data is still stored at addr 3, and the flag clears on the next `arm`.
6. Reset mid-frame. Stimulus: assert `s_axis_aresetn`=0 after beat 5. Required: next cycle `tready`=0, `beat_count`=0, IDLE. Addr 0..5 still hold the written data. A second `arm` then captures a full frame cleanly.

Source files
------------

// File: rtl/axis_frame_capture.sv
// axis_frame_capture
//   AXI4-Stream sink that captures one frame of beats into an internal
//   dual-port buffer, checks the frame length against FRAME_LEN and the byte
//   strobes, then holds the frame for random-access readback.
//
// Ports
//   s_axis_aclk     : clock, all logic rising-edge
//   s_axis_aresetn  : synchronous active-low reset
//   S_AXIS_tdata    : stream data
//   S_AXIS_tstrb    : byte strobes, all-ones expected
//   S_AXIS_tlast    : last beat of frame
//   S_AXIS_tvalid   : source has a beat
//   S_AXIS_tready   : sink accepts a beat (registered)
//   arm             : one-cycle pulse that starts a capture (ignored while busy)
//   busy            : capture in progress
//   done            : frame captured, buffer holding
//   beat_count      : beats accepted in the current or last frame
//   err_len         : sticky, frame length mismatch
//   err_strb        : sticky, a beat carried a partial strobe
//   rd_addr         : readback address
//   rd_data         : mem[rd_addr], one-cycle latency, read-first
module axis_frame_capture #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int ADDRW              = 14,
  parameter int FRAME_LEN          = 16384
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_tstrb,
  input  logic                            S_AXIS_tlast,
  input  logic                            S_AXIS_tvalid,
  output logic                            S_AXIS_tready,
  input  logic                            arm,
  output logic                            busy,
  output logic                            done,
  output logic [ADDRW:0]                  beat_count,
  output logic                            err_len,
  output logic                            err_strb,
  input  logic [ADDRW-1:0]                rd_addr,
  output logic [S_AXIS_TDATA_WIDTH-1:0]   rd_data
);

  localparam logic [ADDRW:0] FRAME_LEN_C = (ADDRW+1)'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    tready_q;
  logic [ADDRW-1:0]        wr_addr_q, wr_addr_d;
  logic [ADDRW:0]          beat_count_q, beat_count_d;
  logic                    err_len_q, err_len_d;
  logic                    err_strb_q, err_strb_d;
  logic [S_AXIS_TDATA_WIDTH-1:0] rd_data_q;
  logic [S_AXIS_TDATA_WIDTH-1:0] mem [2**ADDRW];

  logic           accept;
  logic           start;
  logic [ADDRW:0] n_beats;
  logic           len_hit;

  // tready_q is only ever high in CAPTURE, so a handshake implies CAPTURE.
  assign accept  = S_AXIS_tvalid && tready_q;
  assign start   = arm && (state_q != CAPTURE);
  assign n_beats = beat_count_q + 1'b1;
  assign len_hit = (n_beats == FRAME_LEN_C);

  // State register; tready is registered from the next state so it drops on
  // the same edge that accepts the final beat.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q  <= IDLE;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d == CAPTURE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm) state_d = CAPTURE;
      CAPTURE: if (accept && (S_AXIS_tlast || len_hit)) state_d = DONE;
      DONE:    if (arm) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    busy = (state_q == CAPTURE);
    done = (state_q == DONE);
  end

  // Counters and sticky error flags
  always_comb begin
    wr_addr_d    = wr_addr_q;
    beat_count_d = beat_count_q;
    err_len_d    = err_len_q;
    err_strb_d   = err_strb_q;
    if (start) begin
      wr_addr_d    = '0;
      beat_count_d = '0;
      err_len_d    = 1'b0;
      err_strb_d   = 1'b0;
    end else if (accept) begin
      wr_addr_d    = wr_addr_q + 1'b1;
      beat_count_d = n_beats;
      if (S_AXIS_tstrb != '1) err_strb_d = 1'b1;
      // Early tlast or missing tlast at the length limit.
      if (S_AXIS_tlast != len_hit) err_len_d = 1'b1;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      wr_addr_q    <= '0;
      beat_count_q <= '0;
      err_len_q    <= 1'b0;
      err_strb_q   <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      beat_count_q <= beat_count_d;
      err_len_q    <= err_len_d;
      err_strb_q   <= err_strb_d;
    end
  end

  // Capture buffer: not reset, so a partial frame survives a mid-frame reset.
  // Read and write share one block, giving read-first behaviour on collision.
  always_ff @(posedge s_axis_aclk) begin
    if (accept) mem[wr_addr_q] <= S_AXIS_tdata;
    rd_data_q <= mem[rd_addr];
  end

  assign S_AXIS_tready = tready_q;
  assign beat_count    = beat_count_q;
  assign err_len       = err_len_q;
  assign err_strb      = err_strb_q;
  assign rd_data       = rd_data_q;

endmodule
